mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one physical word-wide memory port between the instruction-fetch requester (port A, read-only) and the data requester (port B, read/write with byte mask) of the five-stage rv32i core.
- Sits between the core's two memory ports and the single downstream memory or cache port.
- Serialises requests, latches the request fields at grant and routes the response back to the granted requester only.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin on conflict; 1 = port B always wins a conflict.
- INIT_LAST_GRANT_B, 0: initial value of last_grant; 0 means A was last granted, so B wins the first conflict.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- read_a  in  1  port A read request, held until resp_a
- address_a  in  32  port A word address
- resp_a  out  1  port A completion pulse
- rdata_a  out  32  port A read data, valid with resp_a
- read_b  in  1  port B read request, held until resp_b
- write  in  1  port B write request, held until resp_b
- wmask  in  4  port B byte-write mask
- address_b  in  32  port B address
- wdata  in  32  port B write data
- resp_b  out  1  port B completion pulse
- rdata_b  out  32  port B read data, valid with resp_b
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_wmask  out  4  downstream byte mask
- mem_address  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_resp  in  1  downstream completion
- mem_rdata  in  32  downstream read data

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Types: all words are rv32i_word.
- FSM states: IDLE, GRANT_A, GRANT_B.
- Reset values:
  - state = IDLE; last_grant = INIT_LAST_GRANT_B.
  - Latched address, wdata, wmask and op all 0.
  - All outputs 0.
  - Reset asserted mid-transaction abandons it: no resp is issued, and downstream strobes drop asynchronously.
- IDLE:
  - req_a = read_a; req_b = read_b | write.
  - Only req_a: go to GRANT_A and latch address_a, op = read.
  - Only req_b: go to GRANT_B and latch address_b, wdata, wmask and op.
  - Both: winner per FIXED_PRIORITY. With round-robin, the winner is the port not equal to last_grant.
  - Neither: stay in IDLE.
  - Decision is registered, so downstream strobes assert the cycle after the request is seen. Minimum latency is request to resp = 2 cycles when mem_resp returns in the first grant cycle.
- GRANT_A / GRANT_B:
  - Drive mem_* from the latched registers, not the live inputs.
  - mem_write = 1 only for a latched B write.
  - mem_wmask = latched wmask on writes, 4'b0000 on reads.
  - When mem_resp = 1: assert the granted port's resp combinationally the same cycle, with rdata = mem_rdata, and set last_grant. Next state is IDLE.
  - Non-granted resp stays 0 and non-granted rdata is 0.
  - Both strobes deassert in IDLE.
- read_b and write both high: protocol violation; treated as write.
- The mandatory IDLE cycle after every resp guarantees a request still held in the resp cycle is never double-served. A request present in IDLE is always a new request.
- Requester input changes while granted are ignored until the next IDLE.
- mem_resp while in IDLE is ignored and produces no resp.
- Starvation bound (round-robin): a waiting port is served within one foreign transaction.

Decomposition:
- Package rv32i_types (existing): rv32i_word.
- Add to the package: enum arb_state_t {IDLE, GRANT_A, GRANT_B} and a packed struct mem_req_t {addr, wdata, wmask, write}.
- One natural sub-module, arb_req_latch: registers mem_req_t on a load enable with async clear. The FSM stays in the top.

Test Plan:
- Single A read:
  - Stimulus: read_a=1, address_a=0x0000_0060, memory answers 0x0000_0013 after 3 cycles.
  - Required: mem_read rises 1 cycle after read_a; resp_a pulses 1 cycle with rdata_a=0x0000_0013; resp_b stays 0.
- B byte write:
  - Stimulus: write=1, address_b=0x0000_1004, wdata=0xDEAD_BEEF, wmask=4'b0010.
  - Required: downstream shows exactly these values with mem_write=1; resp_b pulses once; state then returns to IDLE.
- Simultaneous requests, round-robin, after reset:
  - Stimulus: read_a and read_b both held high.
  - Required: B is granted first, then A after one IDLE cycle.
  - Repeat with requests re-raised: A wins the next conflict.
- FIXED_PRIORITY=1:
  - Stimulus: three back-to-back conflicts.
  - Required: B wins all three; A is served only when B is idle.
- Held request after resp:
  - Stimulus: read_a held one extra cycle after resp_a.
  - Required: exactly one IDLE cycle, then a second A transaction starts. No resp is issued without mem_resp.
- Reset mid-grant:
  - Stimulus: drop reset_n during GRANT_B, before mem_resp.
  - Required: mem_write=0 immediately, no resp_b, state=IDLE.
  - After release, a fresh read_a is served normally.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rv32i core types, extended with the memory-port arbiter state and
// the request record that is captured when a grant is made.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    typedef struct packed {
        rv32i_word addr;
        rv32i_word wdata;
        rv32i_mask wmask;
        logic      write;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_CLEAR = '0;

    // Port A is read-only, so its request record never carries write data.
    function automatic mem_req_t make_read_req(input rv32i_word addr);
        mem_req_t r;
        r       = MEM_REQ_CLEAR;
        r.addr  = addr;
        return r;
    endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Holds the request record of the granted port for the whole transaction,
// so downstream fields stay stable while requesters change their inputs.
module arb_req_latch
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     load,
    input  mem_req_t d,
    output mem_req_t q
);

    // NOTE: sequential state is written with <= only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= MEM_REQ_CLEAR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch (A, read-only)
// and data access (B, read/write), one transaction at a time.
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter bit FIXED_PRIORITY    = 1'b0,
    parameter bit INIT_LAST_GRANT_B = 1'b0
) (
    input  logic      clk,
    input  logic      reset_n,

    input  logic      read_a,
    input  rv32i_word address_a,
    output logic      resp_a,
    output rv32i_word rdata_a,

    input  logic      read_b,
    input  logic      write,
    input  rv32i_mask wmask,
    input  rv32i_word address_b,
    input  rv32i_word wdata,
    output logic      resp_b,
    output rv32i_word rdata_b,

    output logic      mem_read,
    output logic      mem_write,
    output rv32i_mask mem_wmask,
    output rv32i_word mem_address,
    output rv32i_word mem_wdata,
    input  logic      mem_resp,
    input  rv32i_word mem_rdata
);

    arb_state_t state;
    logic       last_grant;   // 1: port B was granted most recently
    logic       req_a;
    logic       req_b;
    logic       pick_b;
    logic       load;
    mem_req_t   next_req;
    mem_req_t   cur_req;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        req_a    = read_a;
        req_b    = read_b | write;
        pick_b   = 1'b0;
        next_req = make_read_req(address_a);

        if (req_a && req_b) begin
            pick_b = FIXED_PRIORITY ? 1'b1 : !last_grant;
        end else begin
            pick_b = req_b;
        end

        // read_b together with write is a protocol violation; write wins.
        if (pick_b) begin
            next_req.addr  = address_b;
            next_req.wdata = wdata;
            next_req.wmask = wmask;
            next_req.write = write;
        end

        load = (state == IDLE) && (req_a || req_b);
    end

    arb_req_latch u_req_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .d       (next_req),
        .q       (cur_req)
    );

    // The unconditional return to IDLE after a response is what keeps a
    // request still held in the response cycle from being served twice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= INIT_LAST_GRANT_B;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= pick_b ? GRANT_B : GRANT_A;
                    end
                end
                GRANT_A: begin
                    if (mem_resp) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                    end
                end
                GRANT_B: begin
                    if (mem_resp) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode only the registered state and latched op, so they fall
    // immediately when reset clears the state.
    always_comb begin
        mem_read    = (state == GRANT_A) || ((state == GRANT_B) && !cur_req.write);
        mem_write   = (state == GRANT_B) && cur_req.write;
        mem_wmask   = mem_write ? cur_req.wmask : 4'b0000;
        mem_address = cur_req.addr;
        mem_wdata   = cur_req.wdata;

        resp_a  = (state == GRANT_A) && mem_resp;
        resp_b  = (state == GRANT_B) && mem_resp;
        rdata_a = resp_a ? mem_rdata : '0;
        rdata_b = resp_b ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance and a
// fixed-priority instance share requester inputs but have separate memories.
module tb_mem_port_arbiter;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_a, read_b, write;
    logic [31:0] address_a, address_b, wdata;
    logic [3:0]  wmask;

    logic        resp_a, resp_b, mem_read, mem_write, mem_resp;
    logic [31:0] rdata_a, rdata_b, mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    logic        resp_a_f, resp_b_f, mem_read_f, mem_write_f, mem_resp_f;
    logic [31:0] rdata_a_f, rdata_b_f, mem_address_f, mem_wdata_f, mem_rdata_f;
    logic [3:0]  mem_wmask_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FIXED_PRIORITY(1'b0), .INIT_LAST_GRANT_B(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
        .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.FIXED_PRIORITY(1'b1), .INIT_LAST_GRANT_B(1'b0)) dut_f (
        .clk(clk), .reset_n(reset_n),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a_f), .rdata_a(rdata_a_f),
        .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
        .wdata(wdata), .resp_b(resp_b_f), .rdata_b(rdata_b_f),
        .mem_read(mem_read_f), .mem_write(mem_write_f), .mem_wmask(mem_wmask_f),
        .mem_address(mem_address_f), .mem_wdata(mem_wdata_f),
        .mem_resp(mem_resp_f), .mem_rdata(mem_rdata_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        read_a = 1'b0; read_b = 1'b0; write = 1'b0;
        address_a = '0; address_b = '0; wdata = '0; wmask = '0;
        mem_resp = 1'b0; mem_rdata = '0; mem_resp_f = 1'b0; mem_rdata_f = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        read_a = 1'b1; address_a = 32'h1234_5678;
        reset_n = 1'b0;
        tick();
        tick();
        total++; if ({mem_read, mem_write, mem_wmask} !== 6'b0) begin bad++; $display("FAIL reset_strobes got=%b want=000000", {mem_read, mem_write, mem_wmask}); end
        total++; if ({mem_address, mem_wdata} !== 64'h0) begin bad++; $display("FAIL reset_fields got=%h want=0", {mem_address, mem_wdata}); end
        total++; if ({resp_a, resp_b, rdata_a, rdata_b} !== 66'h0) begin bad++; $display("FAIL reset_resp got=%h want=0", {resp_a, resp_b, rdata_a, rdata_b}); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE); end
        clear_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_single_a_read();
        do_reset();
        read_a = 1'b1; address_a = 32'h0000_0060;
        #1;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL a_read_same_cycle got=%b want=0", mem_read); end
        tick();
        total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL a_read_strobe got=%b%b want=10", mem_read, mem_write); end
        total++; if (mem_address !== 32'h0000_0060 || mem_wmask !== 4'b0000) begin bad++; $display("FAIL a_read_addr got=%h/%b want=00000060/0000", mem_address, mem_wmask); end
        address_a = 32'hFFFF_FFF0;
        tick();
        total++; if (mem_address !== 32'h0000_0060 || resp_a !== 1'b0) begin bad++; $display("FAIL a_read_hold got=%h/%b want=00000060/0", mem_address, resp_a); end
        tick();
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        total++; if (resp_a !== 1'b1 || rdata_a !== 32'h0000_0013) begin bad++; $display("FAIL a_read_resp got=%b/%h want=1/00000013", resp_a, rdata_a); end
        total++; if (resp_b !== 1'b0 || rdata_b !== 32'h0) begin bad++; $display("FAIL a_read_other_port got=%b/%h want=0/0", resp_b, rdata_b); end
        tick();
        read_a = 1'b0; mem_resp = 1'b0;
        #1;
        total++; if (resp_a !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL a_read_after got=%b/%b want=0/0", resp_a, mem_read); end
    endtask

    task automatic test_b_write();
        do_reset();
        write = 1'b1; address_b = 32'h0000_1004; wdata = 32'hDEAD_BEEF; wmask = 4'b0010;
        tick();
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL b_write_strobe got=%b%b want=01", mem_read, mem_write); end
        total++; if (mem_address !== 32'h0000_1004 || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'b0010) begin bad++; $display("FAIL b_write_fields got=%h/%h/%b want=00001004/deadbeef/0010", mem_address, mem_wdata, mem_wmask); end
        address_b = 32'h0; wdata = 32'h0; wmask = 4'b1111;
        mem_resp = 1'b1; mem_rdata = 32'hAAAA_5555;
        #1;
        total++; if (mem_address !== 32'h0000_1004 || mem_wmask !== 4'b0010) begin bad++; $display("FAIL b_write_latched got=%h/%b want=00001004/0010", mem_address, mem_wmask); end
        total++; if (resp_b !== 1'b1 || resp_a !== 1'b0 || rdata_a !== 32'h0) begin bad++; $display("FAIL b_write_resp got=%b/%b/%h want=1/0/0", resp_b, resp_a, rdata_a); end
        tick();
        write = 1'b0; mem_resp = 1'b0;
        #1;
        total++; if (dut.state !== IDLE || mem_write !== 1'b0 || resp_b !== 1'b0) begin bad++; $display("FAIL b_write_idle got=%0d/%b/%b want=0/0/0", dut.state, mem_write, resp_b); end
        // read_b together with write must behave as a write
        read_b = 1'b1; write = 1'b1; address_b = 32'h0000_2000; wmask = 4'b1001;
        tick();
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wmask !== 4'b1001) begin bad++; $display("FAIL b_both_ops got=%b%b/%b want=01/1001", mem_read, mem_write, mem_wmask); end
        mem_resp = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        read_a = 1'b1; address_a = 32'h0000_00A0;
        read_b = 1'b1; address_b = 32'h0000_00B0;
        tick();
        total++; if (mem_address !== 32'h0000_00B0 || mem_read !== 1'b1) begin bad++; $display("FAIL rr_first_b got=%h/%b want=000000b0/1", mem_address, mem_read); end
        mem_resp = 1'b1; mem_rdata = 32'h0000_0B0B;
        #1;
        total++; if (resp_b !== 1'b1 || resp_a !== 1'b0 || rdata_b !== 32'h0000_0B0B) begin bad++; $display("FAIL rr_first_resp got=%b/%b/%h want=1/0/00000b0b", resp_b, resp_a, rdata_b); end
        tick();
        mem_resp = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL rr_idle_gap got=%b/%0d want=0/0", mem_read, dut.state); end
        tick();
        total++; if (mem_address !== 32'h0000_00A0 || dut.state !== GRANT_A) begin bad++; $display("FAIL rr_second_a got=%h/%0d want=000000a0/1", mem_address, dut.state); end
        mem_resp = 1'b1; mem_rdata = 32'h0000_0A0A;
        #1;
        total++; if (resp_a !== 1'b1 || rdata_a !== 32'h0000_0A0A || resp_b !== 1'b0) begin bad++; $display("FAIL rr_second_resp got=%b/%h/%b want=1/00000a0a/0", resp_a, rdata_a, resp_b); end
        tick();
        mem_resp = 1'b0;
        tick();
        total++; if (mem_address !== 32'h0000_00B0 || dut.state !== GRANT_B) begin bad++; $display("FAIL rr_third_b got=%h/%0d want=000000b0/2", mem_address, dut.state); end
        mem_resp = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        read_a = 1'b1; address_a = 32'h0000_00A0;
        read_b = 1'b1; address_b = 32'h0000_00B0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (mem_address_f !== 32'h0000_00B0 || mem_read_f !== 1'b1) begin bad++; $display("FAIL fp_conflict%0d_grant got=%h/%b want=000000b0/1", k, mem_address_f, mem_read_f); end
            mem_resp_f = 1'b1;
            #1;
            total++; if (resp_b_f !== 1'b1 || resp_a_f !== 1'b0) begin bad++; $display("FAIL fp_conflict%0d_resp got=%b/%b want=1/0", k, resp_b_f, resp_a_f); end
            tick();
            mem_resp_f = 1'b0;
        end
        read_b = 1'b0;
        tick();
        total++; if (mem_address_f !== 32'h0000_00A0 || mem_read_f !== 1'b1) begin bad++; $display("FAIL fp_a_served got=%h/%b want=000000a0/1", mem_address_f, mem_read_f); end
        mem_resp_f = 1'b1; mem_rdata_f = 32'h0000_0777;
        #1;
        total++; if (resp_a_f !== 1'b1 || rdata_a_f !== 32'h0000_0777) begin bad++; $display("FAIL fp_a_resp got=%b/%h want=1/00000777", resp_a_f, rdata_a_f); end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        read_a = 1'b1; address_a = 32'h0000_0080;
        tick();
        mem_resp = 1'b1; mem_rdata = 32'h0000_0011;
        #1;
        total++; if (resp_a !== 1'b1) begin bad++; $display("FAIL held_first_resp got=%b want=1", resp_a); end
        tick();
        mem_resp = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0 || resp_a !== 1'b0) begin bad++; $display("FAIL held_idle got=%b/%b want=0/0", mem_read, resp_a); end
        tick();
        total++; if (mem_read !== 1'b1 || dut.state !== GRANT_A) begin bad++; $display("FAIL held_second_grant got=%b/%0d want=1/1", mem_read, dut.state); end
        tick();
        total++; if (resp_a !== 1'b0 || mem_read !== 1'b1) begin bad++; $display("FAIL held_no_resp got=%b/%b want=0/1", resp_a, mem_read); end
        mem_resp = 1'b1; mem_rdata = 32'h0000_0022;
        #1;
        total++; if (resp_a !== 1'b1 || rdata_a !== 32'h0000_0022) begin bad++; $display("FAIL held_second_resp got=%b/%h want=1/00000022", resp_a, rdata_a); end
        tick();
        read_a = 1'b0;
        #1;
        total++; if (resp_a !== 1'b0 || resp_b !== 1'b0) begin bad++; $display("FAIL idle_mem_resp got=%b/%b want=0/0", resp_a, resp_b); end
        tick();
        total++; if (mem_read !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL idle_stays got=%b/%0d want=0/0", mem_read, dut.state); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        write = 1'b1; address_b = 32'h0000_3000; wdata = 32'h0000_0001; wmask = 4'b1111;
        tick();
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL mid_reset_pre got=%b want=1", mem_write); end
        #2;
        reset_n = 1'b0;
        mem_resp = 1'b1;
        #1;
        total++; if (mem_write !== 1'b0 || resp_b !== 1'b0) begin bad++; $display("FAIL mid_reset_drop got=%b/%b want=0/0", mem_write, resp_b); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL mid_reset_state got=%0d want=0", dut.state); end
        tick();
        clear_inputs();
        reset_n = 1'b1;
        read_a = 1'b1; address_a = 32'h0000_0300;
        tick();
        total++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_0300) begin bad++; $display("FAIL post_reset_grant got=%b/%h want=1/00000300", mem_read, mem_address); end
        mem_resp = 1'b1; mem_rdata = 32'h0000_0055;
        #1;
        total++; if (resp_a !== 1'b1 || rdata_a !== 32'h0000_0055) begin bad++; $display("FAIL post_reset_resp got=%b/%h want=1/00000055", resp_a, rdata_a); end
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b1;
        test_reset();
        test_single_a_read();
        test_b_write();
        test_round_robin();
        test_fixed_priority();
        test_back_to_back();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
